// File: rtl/nic_dma_sequencer.sv
// nic_dma_sequencer
// Per-node DMA engine that moves 64-bit words between the node data memory
// and its NIC without processor help. Two channels share one memory port and
// one NIC port, one word-transfer at a time, round-robin:
//   TX : memory -> NIC output buffer (poll out status, mem read, NIC write)
//   RX : NIC input buffer -> memory  (poll in status, NIC read, mem write)
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   tx_cmd_* / rx_cmd_*          command handshake (base address, word count)
//   tx_done / rx_done            one-cycle completion pulses
//   mem_addr/mem_d_out/mem_d_in  memory port, memEn/memWrEn enables
//   nic_addr/nic_d_in/nic_d_out  NIC port, nicEn/nicWrEn enables
//     NIC map: 00 in buf, 01 in status, 10 out buf, 11 out status (bit 63 = full)
module nic_dma_sequencer #(
    parameter int ADDR_STRIDE = 1,
    parameter int LEN_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_cmd_valid,
    output logic             tx_cmd_ready,
    input  logic [0:31]      tx_cmd_base,
    input  logic [0:LEN_W-1] tx_cmd_len,
    output logic             tx_done,
    input  logic             rx_cmd_valid,
    output logic             rx_cmd_ready,
    input  logic [0:31]      rx_cmd_base,
    input  logic [0:LEN_W-1] rx_cmd_len,
    output logic             rx_done,
    output logic [0:31]      mem_addr,
    output logic [0:63]      mem_d_out,
    input  logic [0:63]      mem_d_in,
    output logic             memEn,
    output logic             memWrEn,
    output logic [0:1]       nic_addr,
    output logic [0:63]      nic_d_in,
    input  logic [0:63]      nic_d_out,
    output logic             nicEn,
    output logic             nicWrEn
);

    typedef enum logic [2:0] {
        ARB, TX_POLL, TX_MRD, TX_NWR, RX_POLL, RX_NRD, RX_MWR
    } state_t;

    localparam logic RR_TX = 1'b0;
    localparam logic RR_RX = 1'b1;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             tx_act_q, tx_act_d, rx_act_q, rx_act_d;
    // Zero-length commands complete without touching the ports; this flag
    // carries the done pulse into the cycle after accept.
    logic             tx_zd_q, tx_zd_d, rx_zd_q, rx_zd_d;
    logic [0:31]      tx_ptr_q, tx_ptr_d, rx_ptr_q, rx_ptr_d;
    logic [0:LEN_W-1] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [0:63]      data_q, data_d;

    // A channel stays busy through its done pulse, so a new command can only
    // land the cycle after done.
    assign tx_cmd_ready = !tx_act_q && !tx_zd_q;
    assign rx_cmd_ready = !rx_act_q && !rx_zd_q;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        tx_act_d  = tx_act_q;
        rx_act_d  = rx_act_q;
        tx_zd_d   = 1'b0;
        rx_zd_d   = 1'b0;
        tx_ptr_d  = tx_ptr_q;
        rx_ptr_d  = rx_ptr_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        data_d    = data_q;
        mem_addr  = '0;
        mem_d_out = '0;
        memEn     = 1'b0;
        memWrEn   = 1'b0;
        nic_addr  = '0;
        nic_d_in  = '0;
        nicEn     = 1'b0;
        nicWrEn   = 1'b0;
        tx_done   = tx_zd_q;
        rx_done   = rx_zd_q;

        // Command accept; the FSM only touches a channel's pointer/count
        // while that channel is active, so these never collide.
        if (tx_cmd_valid && tx_cmd_ready) begin
            tx_ptr_d = tx_cmd_base;
            tx_cnt_d = tx_cmd_len;
            if (tx_cmd_len == '0) tx_zd_d  = 1'b1;
            else                  tx_act_d = 1'b1;
        end
        if (rx_cmd_valid && rx_cmd_ready) begin
            rx_ptr_d = rx_cmd_base;
            rx_cnt_d = rx_cmd_len;
            if (rx_cmd_len == '0) rx_zd_d  = 1'b1;
            else                  rx_act_d = 1'b1;
        end

        unique case (state_q)
            ARB: begin
                if (tx_act_q && (!rx_act_q || rr_q == RR_TX)) state_d = TX_POLL;
                else if (rx_act_q)                            state_d = RX_POLL;
            end
            TX_POLL: begin
                nicEn    = 1'b1;
                nic_addr = 2'b11;
                if (!nic_d_out[63]) begin
                    state_d = TX_MRD;
                end else begin
                    rr_d    = RR_RX;
                    state_d = ARB;
                end
            end
            TX_MRD: begin
                memEn    = 1'b1;
                mem_addr = tx_ptr_q;
                state_d  = TX_NWR;
            end
            TX_NWR: begin
                nicEn    = 1'b1;
                nicWrEn  = 1'b1;
                nic_addr = 2'b10;
                nic_d_in = mem_d_in;
                tx_ptr_d = tx_ptr_q + 32'(ADDR_STRIDE);
                tx_cnt_d = tx_cnt_q - LEN_W'(1);
                rr_d     = RR_RX;
                if (tx_cnt_q == LEN_W'(1)) begin
                    tx_done  = 1'b1;
                    tx_act_d = 1'b0;
                end
                state_d  = ARB;
            end
            RX_POLL: begin
                nicEn    = 1'b1;
                nic_addr = 2'b01;
                if (nic_d_out[63]) begin
                    state_d = RX_NRD;
                end else begin
                    rr_d    = RR_TX;
                    state_d = ARB;
                end
            end
            RX_NRD: begin
                nicEn    = 1'b1;
                nic_addr = 2'b00;
                data_d   = nic_d_out;
                state_d  = RX_MWR;
            end
            RX_MWR: begin
                memEn     = 1'b1;
                memWrEn   = 1'b1;
                mem_addr  = rx_ptr_q;
                mem_d_out = data_q;
                rx_ptr_d  = rx_ptr_q + 32'(ADDR_STRIDE);
                rx_cnt_d  = rx_cnt_q - LEN_W'(1);
                rr_d      = RR_TX;
                if (rx_cnt_q == LEN_W'(1)) begin
                    rx_done  = 1'b1;
                    rx_act_d = 1'b0;
                end
                state_d   = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB;
            rr_q     <= RR_TX;
            tx_act_q <= 1'b0;
            rx_act_q <= 1'b0;
            tx_zd_q  <= 1'b0;
            rx_zd_q  <= 1'b0;
            tx_ptr_q <= '0;
            rx_ptr_q <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            tx_act_q <= tx_act_d;
            rx_act_q <= rx_act_d;
            tx_zd_q  <= tx_zd_d;
            rx_zd_q  <= rx_zd_d;
            tx_ptr_q <= tx_ptr_d;
            rx_ptr_q <= rx_ptr_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: doc/nic_dma_sequencer.md
Name: nic_dma_sequencer

Overview:
- Per-node DMA controller between one node's data memory and its cardinal NIC; moves 64-bit words between the two without processor involvement.
- Two independent channels: TX moves memory to the NIC output buffer; RX moves the NIC input buffer to memory.
- One memory port and one NIC port are shared by both channels, granted one word-transfer at a time, round-robin.
- Sits beside the node processor; top-level muxing onto the memory/NIC ports is outside this block.

Parameters:
- ADDR_STRIDE, 1, memory address increment per 64-bit word.
- LEN_W, 8, width of word-count fields.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- tx_cmd_valid  in  1  TX command request
- tx_cmd_ready  out  1  TX channel idle, command accepted when valid&&ready
- tx_cmd_base  in  [0:31]  TX source memory address
- tx_cmd_len  in  [0:LEN_W-1]  TX word count
- tx_done  out  1  one-cycle pulse, TX command complete
- rx_cmd_valid  in  1  RX command request
- rx_cmd_ready  out  1  RX channel idle
- rx_cmd_base  in  [0:31]  RX destination memory address
- rx_cmd_len  in  [0:LEN_W-1]  RX word count
- rx_done  out  1  one-cycle pulse, RX command complete
- mem_addr  out  [0:31]  memory address
- mem_d_out  out  [0:63]  memory write data
- mem_d_in  in  [0:63]  memory read data, valid the cycle after a read
- memEn  out  1  memory access enable
- memWrEn  out  1  memory write enable (qualified by memEn)
- nic_addr  out  [0:1]  NIC register select
- nic_d_in  out  [0:63]  data to NIC
- nic_d_out  in  [0:63]  data from NIC, combinational during a read
- nicEn  out  1  NIC access enable
- nicWrEn  out  1  NIC write enable (qualified by nicEn)

Behaviour:
- Single clock clk. Reset is synchronous and active-high on reset.
- NIC register map: 2'b00 input buffer (a read clears input full); 2'b01 input status, bit 63 = full; 2'b10 output buffer; 2'b11 output status, bit 63 = full.
- Reset values:
  - State ARB.
  - All enables 0; mem_addr, mem_d_out, nic_addr, nic_d_in all 0.
  - tx_done and rx_done 0; both channels inactive; cmd_ready outputs 1; RR pointer = TX.
- Command accept: a channel latches base into a word pointer and len into a remaining-count; the channel becomes active and its cmd_ready drops the next cycle.
- len = 0: no accesses; the done pulse fires the cycle after accept and the channel returns idle.
- FSM states: ARB, TX_POLL, TX_MRD, TX_NWR, RX_POLL, RX_NRD, RX_MWR.
- ARB:
  - If both channels are active, grant the channel the RR pointer names; otherwise grant the single active channel. Stay in ARB if neither is active.
  - Granting takes one cycle and asserts no enables.
- TX_POLL: nicEn=1, nicWrEn=0, nic_addr=11.
  - If nic_d_out[63]=0, go to TX_MRD.
  - Else go to ARB with RR pointer = RX (no retry lockout).
- TX_MRD: memEn=1, memWrEn=0, mem_addr=pointer. Go to TX_NWR.
- TX_NWR: nicEn=1, nicWrEn=1, nic_addr=10, nic_d_in=mem_d_in.
  - pointer += ADDR_STRIDE, count -= 1, RR pointer = RX.
  - If count was 1, pulse tx_done this cycle and deactivate the channel. Go to ARB.
- RX_POLL: nicEn=1, nic_addr=01.
  - If nic_d_out[63]=1, go to RX_NRD.
  - Else go to ARB with RR pointer = TX.
- RX_NRD: nicEn=1, nic_addr=00; capture nic_d_out into a data register. Go to RX_MWR.
- RX_MWR: memEn=1, memWrEn=1, mem_addr=pointer, mem_d_out=data register.
  - Update pointer and count as TX; RR pointer = TX; rx_done rules as TX. Go to ARB.
- Word cost: TX word = 4 cycles (ARB + 3); RX word = 4 cycles. Throughput is fully interleaved when both channels are active.
- Pointers wrap modulo 2^32 silently.
- A new command may be accepted in the same cycle the done pulse deasserts, i.e. the cycle after done.
- A command presented while the channel is active is ignored (ready=0).
- Reset asserted mid-transfer: everything returns to reset values the next cycle; in-flight words are lost; no done pulse.
- Enables are 0 in every state not listed above. Outputs are registered or decoded from state only; there is no combinational path from cmd_* to mem/NIC outputs.

Test Plan:
- TX basic: output status always 0, tx base=0x10, len=3, mem returns 0xA0,0xA1,0xA2 → three NIC writes to addr 10 with those values; mem addrs 0x10,0x11,0x12; tx_done pulses once, 12 cycles after accept.
- RX backpressure: input status full=0 for 5 polls then 1, nic_d_out=0xBEEF, rx len=1, base=0x40 → single mem write of 0xBEEF at 0x40; rx_done pulses once; no mem access before the full poll.
- Interleave: TX len=2 and RX len=2 accepted in the same cycle, NIC always ready → word order TX,RX,TX,RX; both done pulses appear; 16 cycles total.
- Starvation check: output status stuck full, RX len=2 active → both RX words complete while TX keeps polling; tx_done never pulses until status clears.
- len=0 and ignored command: TX len=0 → tx_done next cycle with no enables. A second TX command while active leaves the pointer and count unchanged.
- Reset mid-op: assert reset during TX_NWR of word 2 of 4 → next cycle all enables 0, cmd_ready=1, no tx_done; a fresh len=1 command then completes normally.
